// File: rtl/ec_data_ctrl.sv
// EC-stage data memory controller: issues SRAM-like load/store requests,
// holds the pipeline while a request is outstanding and returns aligned load data.
module ec_data_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ec_data_req,
  input  logic        ec_load,
  input  logic        ec_loadX,
  input  logic [3:0]  ec_lsV,
  input  logic [31:0] ec_res,
  input  logic [31:0] ec_B,
  input  logic        ec_exc,
  input  logic        flush,
  input  logic        wb_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_stall,
  output logic        ld_valid,
  output logic [31:0] ld_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state_q;
  logic        cancel_q;
  logic        ld_valid_q;
  logic [31:0] ld_data_q;
  logic [31:0] addr_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  off_q;
  logic        loadx_q;

  logic        start;
  logic        cancel_eff;
  logic        complete;
  logic [1:0]  in_size;
  logic [31:0] in_wdata;
  logic [3:0]  in_wstrb;

  function automatic logic [1:0] size_of(input logic [3:0] lsv);
    case (lsv)
      4'b1111:          size_of = 2'd2;
      4'b0011, 4'b1100: size_of = 2'd1;
      default:          size_of = 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [31:0] b, input logic [1:0] sz);
    case (sz)
      2'd0:    wdata_of = {4{b[7:0]}};
      2'd1:    wdata_of = {2{b[15:0]}};
      default: wdata_of = b;
    endcase
  endfunction

  function automatic logic [31:0] ld_ext(input logic [31:0] rd, input logic [1:0] sz,
                                         input logic [1:0] off, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'd0:    ld_ext = {{24{sx & b[7]}}, b};
      2'd1:    ld_ext = {{16{sx & h[15]}}, h};
      default: ld_ext = rd;
    endcase
  endfunction

  assign start      = ec_data_req & ~ec_exc & ~flush;
  assign cancel_eff = cancel_q | flush;
  assign complete   = ((state_q == S_REQ) & data_addr_ok & data_data_ok) |
                      ((state_q == S_WAIT) & data_data_ok);
  assign in_size    = size_of(ec_lsV);
  assign in_wdata   = wdata_of(ec_B, in_size);
  assign in_wstrb   = ec_load ? 4'b0000 : ec_lsV;

  // In IDLE the request is presented straight from the EC inputs; afterwards from the latches.
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = 32'd0;
    data_wdata = 32'd0;
    data_wstrb = 4'b0000;
    mem_stall  = 1'b0;
    if (resetn) begin
      if (state_q == S_IDLE) begin
        data_req   = start;
        data_wr    = ~ec_load;
        data_size  = in_size;
        data_addr  = ec_res;
        data_wdata = in_wdata;
        data_wstrb = in_wstrb;
        mem_stall  = start;
      end else begin
        data_req   = (state_q == S_REQ);
        data_wr    = wr_q;
        data_size  = size_q;
        data_addr  = addr_q;
        data_wdata = wdata_q;
        data_wstrb = wstrb_q;
        mem_stall  = (state_q == S_REQ) | (state_q == S_WAIT);
      end
    end
  end

  assign ld_valid = ld_valid_q;
  assign ld_data  = ld_data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cancel_q   <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= 32'd0;
      addr_q     <= 32'd0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'b0000;
      off_q      <= 2'd0;
      loadx_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cancel_q <= 1'b0;
          if (start) begin
            addr_q  <= ec_res;
            wr_q    <= ~ec_load;
            size_q  <= in_size;
            wdata_q <= in_wdata;
            wstrb_q <= in_wstrb;
            off_q   <= ec_res[1:0];
            loadx_q <= ec_loadX;
            if (data_addr_ok && data_data_ok) begin
              state_q <= S_DONE;
              if (ec_load) begin
                ld_data_q  <= ld_ext(data_rdata, in_size, ec_res[1:0], ec_loadX);
                ld_valid_q <= 1'b1;
              end
            end else if (data_addr_ok) begin
              state_q <= S_WAIT;
            end else begin
              state_q <= S_REQ;
            end
          end
        end
        S_REQ, S_WAIT: begin
          // A flush cannot withdraw an issued request; it only drops the returned data.
          if (complete) begin
            if (cancel_eff) begin
              state_q  <= S_IDLE;
              cancel_q <= 1'b0;
            end else begin
              state_q <= S_DONE;
              if (!wr_q) begin
                ld_data_q  <= ld_ext(data_rdata, size_q, off_q, loadx_q);
                ld_valid_q <= 1'b1;
              end
            end
          end else begin
            if ((state_q == S_REQ) && data_addr_ok) state_q <= S_WAIT;
            cancel_q <= cancel_eff;
          end
        end
        default: begin
          if (!wb_stall) begin
            state_q    <= S_IDLE;
            ld_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ec_data_ctrl.sv
// Directed and randomized checks of ec_data_ctrl against a behavioural memory-access model.
module tb_ec_data_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ec_data_req, ec_load, ec_loadX, ec_exc, flush, wb_stall;
  logic [3:0]  ec_lsV;
  logic [31:0] ec_res, ec_B;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        mem_stall, ld_valid;
  logic [31:0] ld_data;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  ec_data_ctrl dut (
    .clk(clk), .resetn(resetn),
    .ec_data_req(ec_data_req), .ec_load(ec_load), .ec_loadX(ec_loadX), .ec_lsV(ec_lsV),
    .ec_res(ec_res), .ec_B(ec_B), .ec_exc(ec_exc), .flush(flush), .wb_stall(wb_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_stall(mem_stall), .ld_valid(ld_valid), .ld_data(ld_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ec_data_req = 0; ec_load = 0; ec_loadX = 0; ec_lsV = 0; ec_res = 0; ec_B = 0;
    ec_exc = 0; flush = 0; wb_stall = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  task automatic drive(input logic ld, input logic sx, input logic [3:0] lsv,
                       input logic [31:0] res, input logic [31:0] b);
    ec_data_req = 1; ec_load = ld; ec_loadX = sx; ec_lsV = lsv; ec_res = res; ec_B = b;
    ec_exc = 0; flush = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference: pick the addressed byte/half by shifting, then extend.
  function automatic logic [31:0] m_load(input logic [31:0] rd, input int sz, input int off, input bit sx);
    logic [31:0] v, mask;
    int bits;
    if (sz == 2) return rd;
    bits = 8 << sz;
    mask = (32'd1 << bits) - 32'd1;
    v = (rd >> (8 * off)) & mask;
    if (sx && ((v >> (bits - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] b, input int sz);
    if (sz == 0) return {24'd0, b[7:0]} * 32'h0101_0101;
    if (sz == 1) return {16'd0, b[15:0]} * 32'h0001_0001;
    return b;
  endfunction

  int          stalls, sz, off, a, d, w;
  bit          ld, sx;
  logic [31:0] addr, bval, rd, exp_ld;
  logic [3:0]  lsv;

  initial begin
    clr();
    resetn = 0;
    ec_data_req = 1; ec_res = 32'h1234_5678; ec_B = 32'hFFFF_FFFF; ec_lsV = 4'hF;
    #2;
    chk("rst_req", data_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_wdata", data_wdata, 0);
    chk("rst_wstrb", data_wstrb, 0);
    chk("rst_size", data_size, 0);
    chk("rst_wr", data_wr, 0);
    chk("rst_ldv", ld_valid, 0);
    chk("rst_ldd", ld_data, 0);
    tick(); tick();
    clr();
    resetn = 1;
    tick();

    // lb with sign extension, addr_ok same cycle, data_ok two cycles later
    stalls = 0;
    tick(); drive(1, 1, 4'b1000, 32'h1003, 0); data_addr_ok = 1; #1;
    stalls += mem_stall;
    chk("lb_req", data_req, 1);
    chk("lb_size", data_size, 0);
    chk("lb_addr", data_addr, 32'h1003);
    chk("lb_wstrb", data_wstrb, 0);
    chk("lb_wr", data_wr, 0);
    tick(); data_addr_ok = 0; #1;
    stalls += mem_stall;
    chk("lb_req_wait", data_req, 0);
    tick(); data_data_ok = 1; data_rdata = 32'h80FF_FFFF; #1;
    stalls += mem_stall;
    tick(); clr(); #1;
    stalls += mem_stall;
    chk("lb_stalls", stalls, 3);
    chk("lb_ldv", ld_valid, 1);
    chk("lb_ldd", ld_data, 32'hFFFF_FF80);
    tick(); #1;
    chk("lb_ldv_1cyc", ld_valid, 0);

    // sh upper half
    tick(); drive(0, 0, 4'b1100, 32'h2002, 32'h1234_ABCD); data_addr_ok = 1; #1;
    chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
    chk("sh_wstrb", data_wstrb, 4'b1100);
    chk("sh_size", data_size, 1);
    chk("sh_wr", data_wr, 1);
    tick(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h5555_5555; #1;
    chk("sh_ldv_wait", ld_valid, 0);
    tick(); clr(); #1;
    chk("sh_ldv_done", ld_valid, 0);
    chk("sh_ldd_kept", ld_data, 32'hFFFF_FF80);
    chk("sh_stall_done", mem_stall, 0);
    tick(); #1;
    chk("sh_ldv_after", ld_valid, 0);

    // lhu with delayed addr_ok and a flush while the request is pending
    tick(); drive(1, 0, 4'b1100, 32'h3002, 0); #1;
    chk("lhu_req0", data_req, 1);
    tick(); #1;
    chk("lhu_req1", data_req, 1);
    tick(); clr(); flush = 1; #1;
    chk("lhu_req_flush", data_req, 1);
    chk("lhu_addr_flush", data_addr, 32'h3002);
    chk("lhu_size_flush", data_size, 1);
    chk("lhu_stall_flush", mem_stall, 1);
    tick(); flush = 0; data_addr_ok = 1; #1;
    chk("lhu_req3", data_req, 1);
    chk("lhu_addr3", data_addr, 32'h3002);
    tick(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hBEEF_0000; #1;
    chk("lhu_stall_wait", mem_stall, 1);
    tick(); clr(); #1;
    chk("lhu_ldv", ld_valid, 0);
    chk("lhu_idle_req", data_req, 0);
    chk("lhu_idle_stall", mem_stall, 0);
    chk("lhu_ldd_kept", ld_data, 32'hFFFF_FF80);
    tick(); #1;
    chk("lhu_ldv2", ld_valid, 0);

    // lw carrying an exception
    tick(); drive(1, 0, 4'hF, 32'h7000, 0); ec_exc = 1; data_addr_ok = 1; #1;
    chk("exc_req", data_req, 0);
    chk("exc_stall", mem_stall, 0);
    tick(); #1;
    chk("exc_req2", data_req, 0);
    tick(); clr(); #1;
    chk("exc_ldv", ld_valid, 0);

    // lw completing in one cycle, then held in DONE by wb_stall
    tick(); drive(1, 0, 4'hF, 32'h6000, 0); data_addr_ok = 1; data_data_ok = 1;
    data_rdata = 32'hCAFE_BABE; #1;
    chk("wbs_stall0", mem_stall, 1);
    for (int k = 0; k < 4; k++) begin
      tick(); clr(); wb_stall = 1; data_data_ok = 1; data_rdata = $urandom; #1;
      chk("wbs_ldv", ld_valid, 1);
      chk("wbs_ldd", ld_data, 32'hCAFE_BABE);
      chk("wbs_stall", mem_stall, 0);
    end
    tick(); clr(); #1;
    chk("wbs_ldv_last", ld_valid, 1);
    tick(); #1;
    chk("wbs_idle", ld_valid, 0);
    chk("wbs_ldd_after", ld_data, 32'hCAFE_BABE);

    // reset while waiting for data; late data_ok must be ignored
    tick(); drive(1, 0, 4'hF, 32'h4000, 0); data_addr_ok = 1; #1;
    tick(); data_addr_ok = 0; resetn = 0; #1;
    chk("mrst_req", data_req, 0);
    chk("mrst_stall", mem_stall, 0);
    chk("mrst_addr", data_addr, 0);
    chk("mrst_ldd", ld_data, 0);
    tick(); clr(); resetn = 1; #1;
    chk("mrst_req_rel", data_req, 0);
    tick(); data_data_ok = 1; data_rdata = 32'hDEAD_BEEF; #1;
    chk("mrst_stall_late", mem_stall, 0);
    tick(); clr(); #1;
    chk("mrst_ldv_late", ld_valid, 0);
    chk("mrst_ldd_late", ld_data, 0);
    tick(); drive(1, 0, 4'hF, 32'h5004, 0); data_addr_ok = 1; #1;
    chk("mrst_next_req", data_req, 1);
    tick(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1122_3344; #1;
    tick(); clr(); #1;
    chk("mrst_next_ldv", ld_valid, 1);
    chk("mrst_next_ldd", ld_data, 32'h1122_3344);
    tick(); #1;
    chk("mrst_next_idle", ld_valid, 0);
    exp_ld = 32'h1122_3344;

    // randomized transactions with random handshake latencies
    for (int t = 0; t < 60; t++) begin
      sz   = $urandom_range(0, 2);
      off  = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      lsv  = (sz == 0) ? (4'b0001 << off) : (sz == 1) ? ((off == 2) ? 4'b1100 : 4'b0011) : 4'b1111;
      addr = ($urandom & 32'hFFFF_FFFC) | off;
      bval = $urandom;
      rd   = $urandom;
      ld   = $urandom_range(0, 1);
      sx   = $urandom_range(0, 1);
      a    = $urandom_range(0, 3);
      d    = $urandom_range(0, 3);
      w    = $urandom_range(0, 2);
      stalls = 0;
      for (int c = 0; c <= a + d; c++) begin
        tick();
        if (c == 0) drive(ld, sx, lsv, addr, bval);
        else begin ec_res = $urandom; ec_B = $urandom; ec_loadX = $urandom_range(0, 1); end
        data_addr_ok = (c == a);
        data_data_ok = (c == a + d);
        data_rdata   = (c == a + d) ? rd : $urandom;
        #1;
        stalls += mem_stall;
        chk("rnd_req", data_req, (c <= a) ? 1 : 0);
        if (c <= a) begin
          chk("rnd_addr", data_addr, addr);
          chk("rnd_size", data_size, sz);
          chk("rnd_wr", data_wr, ld ? 0 : 1);
          chk("rnd_wstrb", data_wstrb, ld ? 4'b0000 : lsv);
          chk("rnd_wdata", data_wdata, m_wdata(bval, sz));
        end
      end
      if (ld) exp_ld = m_load(rd, sz, off, sx);
      tick(); clr(); wb_stall = (w > 0); #1;
      chk("rnd_stalls", stalls, a + d + 1);
      chk("rnd_done_stall", mem_stall, 0);
      chk("rnd_ldv", ld_valid, ld);
      chk("rnd_ldd", ld_data, exp_ld);
      for (int k = 1; k <= w; k++) begin
        tick(); wb_stall = (k < w); data_data_ok = $urandom_range(0, 1); data_rdata = $urandom; #1;
        chk("rnd_ldv_hold", ld_valid, ld);
        chk("rnd_ldd_hold", ld_data, exp_ld);
      end
      tick(); clr(); #1;
      chk("rnd_ldv_idle", ld_valid, 0);
      chk("rnd_ldd_idle", ld_data, exp_ld);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ec_data_ctrl.md
EC_DATA_CTRL -- requirements
Module: ec_data_ctrl

Interface
REQ-001 SHALL provide ports (clock and reset first): clk in 1, clock, all state on posedge.
REQ-002 SHALL provide resetn in 1: asynchronous, active-low reset.
REQ-003 SHALL provide ec_data_req in 1: the EC instruction is a load/store.
REQ-004 SHALL provide ec_load in 1: load (1) or store (0).
REQ-005 SHALL provide ec_loadX in 1: sign-extend the load result (1) or zero-extend it (0).
REQ-006 SHALL provide ec_lsV in 4: byte-lane mask; legal values 0001/0010/0100/1000/0011/1100/1111.
REQ-007 SHALL provide ec_res in 32: byte address.
REQ-008 SHALL provide ec_B in 32: store data.
REQ-009 SHALL provide ec_exc in 1: the EC instruction carries an exception.
REQ-010 SHALL provide flush in 1: pipeline refresh.
REQ-011 SHALL provide wb_stall in 1: the downstream stage is stalled.
REQ-012 SHALL provide data_req out 1, data_wr out 1, data_size out 2, data_addr out 32, data_wdata out 32, data_wstrb out 4: SRAM-like request channel.
REQ-013 SHALL provide data_addr_ok in 1, data_data_ok in 1, data_rdata in 32: SRAM-like response.
REQ-014 SHALL provide mem_stall out 1 (freeze EX/EC), ld_valid out 1, ld_data out 32.

Function
REQ-015 SHALL implement FSM IDLE, REQ, WAIT, DONE; start = ec_data_req & ~ec_exc & ~flush.
REQ-016 IDLE: data_req SHALL equal start and drive fields combinationally from inputs; on start the fields SHALL be latched (addr, wr, size, wdata, wstrb, ec_res[1:0], ec_loadX).
REQ-017 IDLE: start & data_addr_ok SHALL go to WAIT; start & ~data_addr_ok SHALL go to REQ.
REQ-018 REQ: data_req=1 with latched fields; data_addr_ok SHALL go to WAIT; the request SHALL never be withdrawn, even on flush.
REQ-019 WAIT: data_data_ok SHALL go to DONE, or to IDLE if cancel=1.
REQ-020 DONE: ld_valid=1, ld_data held stable; SHALL return to IDLE when wb_stall=0.
REQ-021 cancel SHALL set on flush in REQ or WAIT, clear on entry to IDLE; cancelled transactions SHALL never assert ld_valid.
REQ-022 mem_stall SHALL equal (IDLE & start) | REQ | WAIT; it SHALL be 0 in DONE.
REQ-023 data_size SHALL be 0 for a one-bit lsV, 1 for two bits, 2 for 1111.
REQ-024 data_wstrb SHALL equal ec_lsV for a store and 0000 for a load; data_wr = ~ec_load.
REQ-025 data_wdata SHALL be: byte -> {4{ec_B[7:0]}}; half -> {2{ec_B[15:0]}}; word -> ec_B.
REQ-026 data_addr SHALL equal ec_res unmodified.
REQ-027 ld_data SHALL be registered on data_data_ok: byte = rdata[8*off+7:8*off]; half = rdata[16*off[1]+15:16*off[1]]; word = rdata; extended per the latched loadX.
REQ-028 A store SHALL also pass through DONE, with ld_valid=0 and ld_data unchanged.
REQ-029 data_addr_ok and data_data_ok in the same cycle while in IDLE/REQ SHALL go straight to DONE, or to IDLE if cancelled, capturing rdata.
REQ-030 data_data_ok in IDLE/DONE SHALL be ignored.

Reset
REQ-031 resetn=0 SHALL asynchronously force IDLE, cancel=0, ld_valid=0, ld_data=0, all latches 0.
REQ-032 During reset, data_req=0 and mem_stall=0; data_wr/size/addr/wdata/wstrb SHALL read 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction; late data_ok SHALL be ignored per REQ-030.

Verification
REQ-034 lb, ec_res=0x1003, loadX=1, addr_ok same cycle, data_ok +2, rdata=0x80FF_FF_FF -> data_size=0, mem_stall 1 for 3 cycles, ld_data=0xFFFFFF80, ld_valid 1 cycle.
REQ-035 sh, ec_res=0x2002, ec_B=0x1234ABCD, lsV=1100 -> data_wdata=0xABCDABCD, wstrb=1100, size=1, wr=1, ld_valid stays 0.
REQ-036 lhu at 0x3002, addr_ok delayed 3 cycles, flush in cycle 2 with inputs zeroed -> data_req held with addr 0x3002 until addr_ok, then data_ok, FSM to IDLE, ld_valid never 1.
REQ-037 lw, ec_exc=1 -> data_req never asserts, mem_stall=0.
REQ-038 lw completes with wb_stall=1 for 4 cycles -> DONE held, ld_data constant, IDLE on the cycle after wb_stall falls.
REQ-039 resetn low in WAIT -> outputs 0 immediately; data_ok after release ignored; next lw completes normally.
